// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined RV32 core.
// Holds the opcode and funct3 constants used by the front end, the default
// reset PC, and the 2-bit saturating counter type used by the branch
// history table together with its update rule.
package cpu_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // 2-bit saturating counter: MSB set means "predict taken"
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_RESET = 2'b01;

  // One training step of a saturating counter
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_pc_unit_bht.sv
// Branch history table: an array of 2-bit saturating counters.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset (all entries -> 01)
//   rd_idx / rd_ctr  combinational read port (shows the pre-update value)
//   wr_en, wr_idx,   saturating training port; the new value becomes
//   wr_taken         visible on the read port from the next cycle
module bht
  import cpu_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int N = 1 << IDX_W;

  ctr_t ctr_q [N];
  ctr_t ctr_d [N];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Read from the registered array so a same-cycle write is not seen
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch-side program-counter unit.
// Owns the fetch PC, predicts branch direction from a BHT of 2-bit counters,
// detects mispredictions from the EX-stage resolution, redirects fetch and
// flushes the younger stages, and keeps branch / mispredict statistics.
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   stall                        hold the PC (overridden by a redirect)
//   if_is_br, if_is_jal,         pre-decode of the fetched instruction and
//   if_target                    its PC-relative target
//   if_pc, if_pred_taken         current fetch PC and its prediction
//   ex_valid, ex_opcode, ex_pc,  resolved instruction in EX with its
//   ex_target, ex_taken,         actual outcome and the prediction that
//   ex_pred_taken                travelled with it
//   flush                        kill IF/ID and ID/EX this cycle
//   br_cnt, miss_cnt             saturating statistics counters
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        if_is_br,
  input  logic        if_is_jal,
  input  logic [31:0] if_target,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  output logic        flush,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic ex_is_branch;
  logic ex_is_cf;
  logic mispredict;
  ctr_t bht_rd_ctr;

  assign ex_is_branch = ex_valid && (ex_opcode == OP_BRANCH);
  assign ex_is_cf     = ex_is_branch || (ex_valid && (ex_opcode == OP_JAL));
  assign mispredict   = ex_is_cf && (ex_taken != ex_pred_taken);

  bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rstn     (rstn),
    .rd_idx   (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr   (bht_rd_ctr),
    .wr_en    (ex_is_branch),
    .wr_idx   (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken (ex_taken)
  );

  // Prediction and flush are gated by rstn so both read 0 while reset is held
  always_comb begin
    if_pred_taken = 1'b0;
    if (rstn) begin
      if (if_is_jal) begin
        if_pred_taken = 1'b1;
      end else if (if_is_br) begin
        if_pred_taken = bht_rd_ctr[1];
      end
    end
  end

  assign flush = mispredict && rstn;

  // Redirect outranks stall: the stalled instruction is being flushed anyway
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (mispredict) begin
      pc_d = ex_taken ? ex_target : (ex_pc + 32'd4);
    end else if (stall) begin
      pc_d = pc_q;
    end else if (if_pred_taken) begin
      pc_d = if_target;
    end
  end

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (ex_is_branch && (br_cnt_q != 32'hFFFF_FFFF)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (mispredict && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      br_cnt_q   <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign if_pc    = pc_q;
  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

  localparam logic [6:0] TB_JAL    = 7'b1101111;
  localparam logic [6:0] TB_BRANCH = 7'b1100011;
  localparam logic [6:0] TB_ALU    = 7'b0110011;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        if_is_br;
  logic        if_is_jal;
  logic [31:0] if_target;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int tests = 0;
  int fails = 0;

  branch_pc_unit dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .if_is_br      (if_is_br),
    .if_is_jal     (if_is_jal),
    .if_target     (if_target),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_taken      (ex_taken),
    .ex_pred_taken (ex_pred_taken),
    .flush         (flush),
    .br_cnt        (br_cnt),
    .miss_cnt      (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: plain PC value, counter table as integers 0..3
  logic [31:0] m_pc;
  int          m_bht [16];
  logic [31:0] m_br;
  logic [31:0] m_miss;
  logic        m_last_flush;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic        flush;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t exp_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'h0000_3000;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_br = 0;
    m_miss = 0;
    m_last_flush = 1'b0;
  endtask

  // Drives one cycle of inputs, records what the DUT should show during this
  // cycle, advances the model across the coming clock edge
  task automatic applyStimulus(input logic st, input logic br, input logic jal,
                               input logic [31:0] tgt, input logic ev,
                               input logic [6:0] op, input logic [31:0] epc,
                               input logic [31:0] etgt, input logic tk,
                               input logic pt);
    exp_t e;
    logic pred, is_cf, is_br_ex, mis;
    int idx;
    stall = st; if_is_br = br; if_is_jal = jal; if_target = tgt;
    ex_valid = ev; ex_opcode = op; ex_pc = epc; ex_target = etgt;
    ex_taken = tk; ex_pred_taken = pt;

    idx = int'(m_pc[5:2]);
    pred = jal ? 1'b1 : (br ? (m_bht[idx] >= 2) : 1'b0);
    is_br_ex = ev && (op == TB_BRANCH);
    is_cf = is_br_ex || (ev && (op == TB_JAL));
    mis = is_cf && (tk != pt);

    e.pc = m_pc; e.pred = pred; e.flush = mis; e.br = m_br; e.miss = m_miss;
    exp_q.push_back(e);

    if (mis) m_pc = tk ? etgt : epc + 32'd4;
    else if (st) m_pc = m_pc;
    else if (pred) m_pc = tgt;
    else m_pc = m_pc + 32'd4;

    if (is_br_ex) begin
      idx = int'(epc[5:2]);
      if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    end
    if (mis && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
    m_last_flush = mis;

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 32'h0, 0, TB_ALU, 32'h0, 32'h0, 0, 0);
  endtask

  // Monitor: the DUT presents a fresh set of outputs every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("if_pc", if_pc, e.pc);
        checkOutput("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, e.pred});
        checkOutput("flush", {31'd0, flush}, {31'd0, e.flush});
        checkOutput("br_cnt", br_cnt, e.br);
        checkOutput("miss_cnt", miss_cnt, e.miss);
      end
    end
  end

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic        r_st, r_br, r_jal, r_ev, r_tk, r_pt;
    logic [6:0]  r_op;
    logic [31:0] r_tgt, r_epc, r_etgt;
    int          guard;

    rstn = 1'b0;
    stall = 0; if_is_br = 0; if_is_jal = 1; if_target = 32'h0;
    ex_valid = 0; ex_opcode = TB_ALU; ex_pc = 0; ex_target = 0;
    ex_taken = 0; ex_pred_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset if_pc", if_pc, 32'h0000_3000);
    checkOutput("reset pred", {31'd0, if_pred_taken}, 32'd0);
    checkOutput("reset flush", {31'd0, flush}, 32'd0);
    checkOutput("reset br_cnt", br_cnt, 32'd0);
    checkOutput("reset miss_cnt", miss_cnt, 32'd0);
    if_is_jal = 0;
    rstn = 1'b1;
    modelReset();

    // Sequential fetch 3000 -> 3004 -> 3008 ... up to 3010
    guard = 0;
    while (m_pc != 32'h0000_3010 && guard < 10) begin
      idle();
      guard++;
    end
    // JAL predicted taken, then resolved correctly
    applyStimulus(0, 0, 1, 32'h3100, 0, TB_ALU, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, TB_JAL, 32'h3010, 32'h3100, 1, 1);
    // Branch at 3020 predicted NT but taken
    applyStimulus(0, 0, 0, 0, 1, TB_BRANCH, 32'h3020, 32'h3040, 1, 0);
    idle();
    // Redirect back to 3020 via a JAL mispredict, then fetch branch there
    applyStimulus(0, 0, 0, 0, 1, TB_JAL, 32'h3044, 32'h3020, 1, 0);
    applyStimulus(0, 1, 0, 32'h3080, 0, TB_ALU, 0, 0, 0, 0);
    // Mispredict under stall: redirect wins
    applyStimulus(1, 0, 0, 0, 1, TB_BRANCH, 32'h3020, 32'h3080, 0, 1);
    // Train index 8 to saturation, then back down
    repeat (4) applyStimulus(0, 0, 0, 0, 1, TB_BRANCH, 32'h3020, 32'h3080, 1, 1);
    repeat (2) applyStimulus(0, 0, 0, 0, 1, TB_BRANCH, 32'h3020, 32'h3080, 0, 0);
    // Stall with no EX activity
    repeat (3) applyStimulus(1, 1, 1, 32'h5000, 0, TB_ALU, 0, 0, 0, 0);
    // PC wrap at the top of the address space
    applyStimulus(0, 0, 0, 0, 1, TB_JAL, 32'h3000, 32'hFFFF_FFFC, 1, 0);
    idle();
    idle();

    // Randomized traffic around a small address region
    for (int n = 0; n < 400; n++) begin
      r_st = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: begin r_br = 1; r_jal = 0; end
        1: begin r_br = 0; r_jal = 1; end
        default: begin r_br = 0; r_jal = 0; end
      endcase
      r_tgt = 32'h0000_3000 + ($urandom_range(0, 63) << 2);
      r_ev = ($urandom_range(0, 1) == 1) && !m_last_flush;
      case ($urandom_range(0, 2))
        0: r_op = TB_JAL;
        1: r_op = TB_BRANCH;
        default: r_op = TB_ALU;
      endcase
      r_epc = 32'h0000_3000 + ($urandom_range(0, 63) << 2);
      r_etgt = 32'h0000_3000 + ($urandom_range(0, 63) << 2);
      r_tk = (r_op == TB_JAL) ? 1'b1 : 1'($urandom_range(0, 1));
      r_pt = 1'($urandom_range(0, 1));
      applyStimulus(r_st, r_br, r_jal, r_tgt, r_ev, r_op, r_epc, r_etgt, r_tk, r_pt);
    end

    // Reset asserted during a mispredict redirect
    stall = 0; if_is_br = 0; if_is_jal = 1; if_target = 32'h4000;
    ex_valid = 1; ex_opcode = TB_BRANCH; ex_pc = 32'h3020; ex_target = 32'h3400;
    ex_taken = 1; ex_pred_taken = 0;
    #2;
    checkOutput("pre-reset flush", {31'd0, flush}, 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("mid-reset flush", {31'd0, flush}, 32'd0);
    checkOutput("mid-reset if_pc", if_pc, 32'h0000_3000);
    checkOutput("mid-reset pred", {31'd0, if_pred_taken}, 32'd0);
    checkOutput("mid-reset br_cnt", br_cnt, 32'd0);
    checkOutput("mid-reset miss_cnt", miss_cnt, 32'd0);
    if_is_jal = 0; ex_valid = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    modelReset();

    // Walk all 16 indices with a branch fetched each cycle: every entry
    // must be back at weakly-not-taken
    repeat (16) applyStimulus(0, 1, 0, 32'h6000, 0, TB_ALU, 0, 0, 0, 0);
    idle();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Fetch-side program-counter unit for the pipelined RV32 core. Owns the PC register, predicts branch direction with a table of 2-bit saturating counters, and consumes the EX-stage branch-compare result (`taken`) to detect mispredictions. On a misprediction it redirects fetch and flushes the younger stages. It also keeps branch and mispredict statistics for the debug bus.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC loaded on reset
- `BHT_IDX_W`, 4, log2 of the number of branch-history-table entries (16)

Ports:
- `clk`  in  1  core clock
- `rstn`  in  1  reset; asynchronous, active-low
- `stall`  in  1  hold the PC (load-use hazard)
- `if_is_br`  in  1  fetched instruction is a conditional branch (pre-decode)
- `if_is_jal`  in  1  fetched instruction is JAL
- `if_target`  in  32  PC + B/J immediate of the fetched instruction
- `if_pc`  out  32  current fetch PC
- `if_pred_taken`  out  1  prediction for the instruction at `if_pc`
- `ex_valid`  in  1  EX holds a valid instruction
- `ex_opcode`  in  7  EX opcode
- `ex_pc`  in  32  EX instruction PC
- `ex_target`  in  32  EX branch/jump target
- `ex_taken`  in  1  compare-unit result (JAL always 1)
- `ex_pred_taken`  in  1  prediction carried down the pipeline with the instruction
- `flush`  out  1  kill IF/ID and ID/EX
- `br_cnt`  out  32  conditional branches resolved
- `miss_cnt`  out  32  mispredictions

## Operation
- Control-flow instruction in EX: `ex_valid` and `ex_opcode` is JAL (7'b1101111) or BRANCH (7'b1100011).
- Mispredict: control-flow instruction in EX and `ex_taken != ex_pred_taken`.
- Prediction:
  - `if_is_jal` -> predict taken.
  - `if_is_br` -> predict `bht[if_pc[BHT_IDX_W+1:2]][1]`.
  - Otherwise predict not taken.
- Next-PC priority, highest first:
  1. Mispredict -> `ex_taken ? ex_target : ex_pc+4`. This overrides `stall`.
  2. `stall` -> hold the PC.
  3. `if_pred_taken` -> `if_target`.
  4. Otherwise `if_pc+4`.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `flush` = mispredict. It is combinational and forced to 0 while `rstn` is low.
- BHT update: on `ex_valid` with a BRANCH opcode, the counter at `ex_pc[BHT_IDX_W+1:2]` is updated.
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
  - JAL never touches the BHT.
  - The update happens regardless of `stall`.
- Same-cycle read and write of one BHT entry: the IF read sees the old value, and the new value is visible from the next cycle.
- `br_cnt` increments on every BRANCH-opcode resolution.
- `miss_cnt` increments on every mispredict (JAL included).
- Both counters saturate at 32'hFFFF_FFFF and do not wrap.

## Timing
- Reset (async assert, sync release):
  - `if_pc` = `RESET_PC`
  - every BHT entry = 2'b01 (weakly not taken)
  - `br_cnt` = `miss_cnt` = 0
  - `flush` = 0
  - `if_pred_taken` = 0
- If reset asserts mid-operation, all of this state is cleared immediately, including any pending redirect.
- `if_pc`, the BHT and both counters update on the rising edge of `clk`.
- `if_pred_taken` is combinational from `if_pc` and the IF inputs.
- Redirect latency:
  - `flush` is high in the same cycle the mispredicting instruction is in EX.
  - `if_pc` holds the corrected target on the next edge.
  - Penalty is two bubbles.
- `flush` is exactly one cycle wide per mispredict. Back-to-back EX mispredicts cannot occur, because the flush removes the younger instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_JAL` and `OP_BRANCH`
  - funct3 constants `F3_BEQ` and `F3_BLT`
  - the `RESET_PC` default
  - the 2-bit counter type and its reset value 2'b01
- One sub-module, `bht`, contains:
  - the counter array
  - async reset
  - combinational read port
  - saturating write port
- PC mux, mispredict logic and statistics live in the top module.

## Test plan
- Reset release -> `if_pc` = 32'h0000_3000; no stall and no control flow -> 32'h3004, then 32'h3008 on successive edges. `flush` = 0, both counters 0.
- JAL at 32'h3010 with `if_target` = 32'h3100 -> `if_pred_taken` = 1 and next `if_pc` = 32'h3100. Later EX with `ex_taken` = 1, `ex_pred_taken` = 1 -> no flush, `miss_cnt` stays 0.
- Branch at 32'h3020 predicted not taken, EX `ex_taken` = 1, `ex_target` = 32'h3040:
  - `flush` = 1 for one cycle and next `if_pc` = 32'h3040
  - `br_cnt` = 1, `miss_cnt` = 1
  - BHT[8] goes 01 -> 10, so the next fetch of 32'h3020 predicts taken.
- Mispredict (actual not taken, `ex_pc` = 32'h3020) while `stall` = 1 -> redirect wins; next `if_pc` = 32'h3024 and `flush` = 1.
- Same index trained taken four times -> counter saturates at 11; two not-taken resolutions -> 01. `stall` held for 3 cycles with no EX activity -> `if_pc` unchanged.
- Assert `rstn` low in the same cycle as a mispredict redirect -> `flush` drops immediately, `if_pc` = 32'h3000, all BHT entries 01.
